// File: rtl/request_unit_if.sv
// request_unit_if: control-unit requests, memory hits and the resulting memory/PC controls.
interface request_unit_if #(parameter int STALL_W = 16);
    logic cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit;
    logic imemREN, dmemREN, dmemWEN, pc_en, halt_out, dmem_timeout;
    logic [STALL_W-1:0] stall_cnt;
    modport master (
        output cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
        input  imemREN, dmemREN, dmemWEN, pc_en, halt_out, dmem_timeout, stall_cnt
    );
    modport slave (
        input  cu_iREN, cu_dREN, cu_dWEN, cu_halt, ihit, dhit,
        output imemREN, dmemREN, dmemWEN, pc_en, halt_out, dmem_timeout, stall_cnt
    );
endinterface

// File: rtl/request_unit.sv
// request_unit: registers data-memory requests, drives PC enable, sticky halt/timeout and a stall counter.
module request_unit #(
    parameter int STALL_W  = 16,
    parameter int DTIMEOUT = 64
) (
    input logic CLK,
    input logic nRST,
    request_unit_if.slave bus
);
    localparam int TW = (DTIMEOUT > 1) ? $clog2(DTIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'((DTIMEOUT == 0) ? 0 : DTIMEOUT - 1);
    typedef enum logic [1:0] {FETCH, DATA, HALTED} state_t;
    state_t state_q;
    logic dren_q, dwen_q, halt_q, tmo_q;
    logic [TW-1:0] tcnt_q;
    logic [STALL_W-1:0] stall_q;
    logic memop, pc_en;
    assign memop = bus.cu_dWEN | bus.cu_dREN;
    always_comb begin
        pc_en = (state_q == FETCH) ? (bus.ihit & ~memop & ~bus.cu_halt) :
                (state_q == DATA)  ? bus.dhit : 1'b0;
    end
    assign bus.pc_en        = pc_en;
    assign bus.imemREN      = (state_q == FETCH) & bus.cu_iREN;
    assign bus.dmemREN      = dren_q;
    assign bus.dmemWEN      = dwen_q;
    assign bus.halt_out     = halt_q;
    assign bus.dmem_timeout = tmo_q;
    assign bus.stall_cnt    = stall_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            halt_q  <= 1'b0;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            if (state_q != HALTED && !pc_en && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            case (state_q)
                FETCH: begin
                    // halt decode outranks any memory op of the same instruction
                    if (bus.ihit && bus.cu_halt) begin
                        state_q <= HALTED;
                        halt_q  <= 1'b1;
                    end else if (bus.ihit && memop) begin
                        state_q <= DATA;
                        dwen_q  <= bus.cu_dWEN;
                        dren_q  <= bus.cu_dREN & ~bus.cu_dWEN;
                        tcnt_q  <= '0;
                    end
                end
                DATA: begin
                    if (bus.dhit) begin
                        state_q <= FETCH;
                        dren_q  <= 1'b0;
                        dwen_q  <= 1'b0;
                    end else begin
                        if (DTIMEOUT != 0 && tcnt_q == TLAST)
                            tmo_q <= 1'b1;
                        if (DTIMEOUT != 0 && tcnt_q != TW'(DTIMEOUT))
                            tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/request_unit.md
Name: request_unit

Overview:
- Consumer end of the control unit's memory-request outputs (iREN, dREN, dWEN, halt) in the single-cycle/multicycle datapath.
- Turns per-instruction control requests into registered memory requests toward the memory controller and tracks ihit/dhit.
- Generates the PC write enable and a sticky halt.
- Counts stall cycles for performance reporting.

Parameters:
STALL_W, 16, width of saturating stall-cycle counter
DTIMEOUT, 64, cycles in DATA without dhit before dmem_timeout asserts (0 disables)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
cu_iREN  input  1  control unit instruction-read request
cu_dREN  input  1  control unit data-read request for the current instruction
cu_dWEN  input  1  control unit data-write request for the current instruction
cu_halt  input  1  control unit halt decode for the current instruction
ihit  input  1  instruction memory response valid
dhit  input  1  data memory response valid
imemREN  output  1  instruction read request to memory controller
dmemREN  output  1  data read request, registered
dmemWEN  output  1  data write request, registered
pc_en  output  1  PC write enable (PC_WEN to datapath)
halt_out  output  1  sticky halt to system
dmem_timeout  output  1  sticky: DATA exceeded DTIMEOUT cycles
stall_cnt  output  STALL_W  saturating count of stall cycles

Behaviour:
- Reset (nRST low, asynchronous):
  - State = FETCH.
  - dmemREN = 0, dmemWEN = 0, halt_out = 0, dmem_timeout = 0, stall_cnt = 0, internal timeout counter = 0.
- States: FETCH, DATA, HALTED.
- memop = cu_dWEN | cu_dREN. If both are asserted, dWEN has priority: only dmemWEN is issued.
- FETCH:
  - imemREN = cu_iREN (combinational).
  - ihit & cu_halt: go to HALTED. halt_out is set at the next edge. pc_en = 0. Halt wins over a simultaneous memop.
  - ihit & memop & !cu_halt:
    - pc_en = 0.
    - Next edge: dmemWEN <= cu_dWEN, dmemREN <= cu_dREN & !cu_dWEN, timeout counter cleared, go to DATA.
  - ihit & !memop & !cu_halt: pc_en = 1 combinationally in the same cycle. Zero added latency. Stay in FETCH.
  - !ihit: pc_en = 0.
  - dhit is ignored in FETCH.
- DATA:
  - imemREN = 0. Data port has priority; no instruction request is issued.
  - dmemREN/dmemWEN are held constant until dhit.
  - dhit:
    - pc_en = 1 in that cycle.
    - Next edge: dmemREN <= 0, dmemWEN <= 0, go to FETCH.
  - !dhit: pc_en = 0. Timeout counter increments.
    - When it reaches DTIMEOUT (DTIMEOUT != 0), dmem_timeout sets and stays set until reset.
    - The request remains asserted; the FSM keeps waiting.
  - ihit is ignored in DATA.
- HALTED:
  - imemREN = dmemREN = dmemWEN = pc_en = 0. halt_out = 1.
  - Exit only via reset. All inputs are ignored.
- Memory-op latency: minimum 2 cycles from fetch ihit to pc_en (ihit cycle, then DATA with dhit in its first cycle).
- stall_cnt increments by 1 on every rising edge where state != HALTED and pc_en = 0. It saturates at 2^STALL_W-1 with no wrap.
- Reset mid-DATA: requests drop immediately (asynchronously). After release the FSM restarts in FETCH; no pending request is replayed.
- All registered outputs change only on the CLK rising edge or asynchronously on nRST falling. pc_en and imemREN are combinational from state and inputs.

Test Plan:
- Reset release; cu_iREN=1, ihit=1, memop=0, halt=0 for 5 cycles -> imemREN=1 and pc_en=1 each cycle; stall_cnt=0; dmem outputs 0.
- Load: ihit=1 with cu_dREN=1 in cycle 0, dhit=1 in cycle 3 -> dmemREN=1 in cycles 1-3, pc_en=1 only in cycle 3, imemREN=0 in cycles 1-3, stall_cnt=3, FETCH in cycle 4.
- Store with cu_dREN=cu_dWEN=1 on ihit, dhit on the first DATA cycle -> dmemWEN=1 and dmemREN=0 for exactly 1 cycle; pc_en pulses once.
- ihit with cu_halt=1 and cu_dWEN=1 -> no dmem request; halt_out=1 from the next edge onward; subsequent ihit/dhit produce no pc_en; stall_cnt frozen; only nRST clears.
- DTIMEOUT=4, load issued, dhit withheld 6 cycles -> dmem_timeout rises after the 4th waiting cycle and stays 1 after a later dhit; then assert nRST mid-DATA -> dmemREN falls immediately, all outputs at reset values.
- STALL_W=3, ihit held 0 for 10 cycles -> stall_cnt saturates at 7 and does not wrap.
